// File: rtl/tc_sram_banked.sv
// Multi-port SRAM built from NumBanks single-port banks, word-interleaved on the
// low address bits, with a round-robin arbiter per bank and a per-port read pipeline.
module tc_sram_banked #(
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned ByteWidth = 8,
  parameter int unsigned NumPorts  = 4,
  parameter int unsigned NumBanks  = 4,
  parameter int unsigned Latency   = 1,
  localparam int unsigned AddrWidth    = (NumWords > 1) ? $clog2(NumWords) : 1,
  localparam int unsigned BeWidth      = (DataWidth + ByteWidth - 1) / ByteWidth,
  localparam int unsigned BankSelWidth = (NumBanks > 1) ? $clog2(NumBanks) : 1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NumPorts-1:0]                req_i,
  output logic [NumPorts-1:0]                gnt_o,
  input  logic [NumPorts-1:0]                we_i,
  input  logic [NumPorts-1:0][AddrWidth-1:0] addr_i,
  input  logic [NumPorts-1:0][DataWidth-1:0] wdata_i,
  input  logic [NumPorts-1:0][BeWidth-1:0]   be_i,
  output logic [NumPorts-1:0]                rvalid_o,
  output logic [NumPorts-1:0][DataWidth-1:0] rdata_o
);

  localparam int unsigned BankShift = (NumBanks > 1) ? $clog2(NumBanks) : 0;
  localparam int unsigned NumRows   = NumWords / NumBanks;
  localparam int unsigned RowWidth  = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam int unsigned PadWidth  = BeWidth * ByteWidth;
  localparam int unsigned PortWidth = (NumPorts > 1) ? $clog2(NumPorts) : 1;

  if (NumPorts < 1 || NumPorts > 8) begin : g_err_ports
    $fatal(1, "tc_sram_banked: NumPorts must be within 1..8");
  end
  if (NumBanks == 0 || NumBanks > 16 || (NumBanks & (NumBanks - 1)) != 0) begin : g_err_banks
    $fatal(1, "tc_sram_banked: NumBanks must be a power of two within 1..16");
  end
  if (NumBanks != 0 && (NumWords % NumBanks) != 0) begin : g_err_words
    $fatal(1, "tc_sram_banked: NumWords must be a multiple of NumBanks");
  end
  if (Latency == 0) begin : g_err_latency
    $fatal(1, "tc_sram_banked: Latency must be at least 1");
  end

  logic [NumPorts-1:0][BankSelWidth-1:0] port_bank;
  logic [NumPorts-1:0][RowWidth-1:0]     port_row;
  logic [NumPorts-1:0]                   port_in_range;

  for (genvar gi = 0; gi < NumPorts; gi++) begin : g_port_dec
    if (NumBanks > 1) begin : g_bank_sel
      assign port_bank[gi] = addr_i[gi][BankSelWidth-1:0];
    end else begin : g_single_bank
      assign port_bank[gi] = '0;
    end
    assign port_row[gi]      = RowWidth'(addr_i[gi] >> BankShift);
    assign port_in_range[gi] = (32'(addr_i[gi]) < NumWords);
  end

  logic [NumBanks-1:0][PortWidth-1:0] ptr_reg, ptr_next;
  logic [NumBanks-1:0][PortWidth-1:0] bank_win;
  logic [NumBanks-1:0]                bank_win_valid;

  // Two passes: ports at or above the pointer first, then the wrapped-around remainder.
  always_comb begin
    bank_win       = '0;
    bank_win_valid = '0;
    gnt_o          = '0;
    ptr_next       = ptr_reg;
    for (int b = 0; b < NumBanks; b++) begin
      for (int p = 0; p < NumPorts; p++) begin
        if (!bank_win_valid[b] && rst_ni && req_i[p] &&
            port_bank[p] == BankSelWidth'(b) && PortWidth'(p) >= ptr_reg[b]) begin
          bank_win[b]       = PortWidth'(p);
          bank_win_valid[b] = 1'b1;
        end
      end
      for (int p = 0; p < NumPorts; p++) begin
        if (!bank_win_valid[b] && rst_ni && req_i[p] &&
            port_bank[p] == BankSelWidth'(b)) begin
          bank_win[b]       = PortWidth'(p);
          bank_win_valid[b] = 1'b1;
        end
      end
      if (bank_win_valid[b]) begin
        gnt_o[bank_win[b]] = 1'b1;
        ptr_next[b] = (bank_win[b] == PortWidth'(NumPorts - 1)) ? '0 : bank_win[b] + 1'b1;
      end
    end
  end

  logic [NumBanks-1:0][PadWidth-1:0] bank_rdata;

  for (genvar gi = 0; gi < NumBanks; gi++) begin : g_bank
    logic [PadWidth-1:0]  mem [NumRows];
    logic [PadWidth-1:0]  dly_reg [Latency];
    logic [PortWidth-1:0] win;
    logic [RowWidth-1:0]  row;
    logic [RowWidth-1:0]  rd_row;
    logic [PadWidth-1:0]  wdata_pad;
    logic [BeWidth-1:0]   be;
    logic                 wr_en;
    logic                 rd_en;

    assign win       = bank_win[gi];
    assign row       = port_row[win];
    assign rd_row    = port_in_range[win] ? row : '0;
    assign wdata_pad = PadWidth'(wdata_i[win]);
    assign be        = be_i[win];
    assign wr_en     = bank_win_valid[gi] && we_i[win] && port_in_range[win];
    assign rd_en     = bank_win_valid[gi] && !we_i[win];

    // The first stage is the RAM's registered read; the rest stretch it to Latency.
    always_ff @(posedge clk_i) begin
      if (wr_en) begin
        for (int i = 0; i < BeWidth; i++) begin
          if (be[i]) begin
            mem[row][i*ByteWidth +: ByteWidth] <= wdata_pad[i*ByteWidth +: ByteWidth];
          end
        end
      end
      if (rd_en) begin
        dly_reg[0] <= mem[rd_row];
      end
      for (int s = 1; s < Latency; s++) begin
        dly_reg[s] <= dly_reg[s-1];
      end
    end

    assign bank_rdata[gi] = dly_reg[Latency-1];
  end

  logic [NumPorts-1:0][Latency-1:0]                   pipe_valid_reg;
  logic [NumPorts-1:0][Latency-1:0]                   pipe_zero_reg;
  logic [NumPorts-1:0][Latency-1:0][BankSelWidth-1:0] pipe_bank_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_reg        <= '0;
      pipe_valid_reg <= '0;
      pipe_zero_reg  <= '0;
      pipe_bank_reg  <= '0;
    end else begin
      ptr_reg <= ptr_next;
      for (int p = 0; p < NumPorts; p++) begin
        pipe_valid_reg[p][0] <= gnt_o[p] & ~we_i[p];
        pipe_zero_reg[p][0]  <= ~port_in_range[p];
        pipe_bank_reg[p][0]  <= port_bank[p];
        for (int s = 1; s < Latency; s++) begin
          pipe_valid_reg[p][s] <= pipe_valid_reg[p][s-1];
          pipe_zero_reg[p][s]  <= pipe_zero_reg[p][s-1];
          pipe_bank_reg[p][s]  <= pipe_bank_reg[p][s-1];
        end
      end
    end
  end

  // Out-of-range reads still return a beat, but with the data forced to zero.
  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    for (int p = 0; p < NumPorts; p++) begin
      rvalid_o[p] = pipe_valid_reg[p][Latency-1];
      if (pipe_valid_reg[p][Latency-1] && !pipe_zero_reg[p][Latency-1]) begin
        rdata_o[p] = bank_rdata[pipe_bank_reg[p][Latency-1]][DataWidth-1:0];
      end
    end
  end

endmodule

// File: tb/tb_tc_sram_banked.sv
// Directed bench for tc_sram_banked: 4 ports, 4 banks, 1000 words, Latency 2.
module tb_tc_sram_banked;
  localparam int NP  = 4;
  localparam int AW  = 10;
  localparam int DW  = 64;
  localparam int BEW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n;
  logic [NP-1:0]          req, gnt, we, rvalid;
  logic [NP-1:0][AW-1:0]  addr;
  logic [NP-1:0][DW-1:0]  wdata, rdata;
  logic [NP-1:0][BEW-1:0] be;

  int n_checks = 0;
  int n_pass   = 0;

  tc_sram_banked #(
    .NumWords (1000),
    .DataWidth(64),
    .ByteWidth(8),
    .NumPorts (4),
    .NumBanks (4),
    .Latency  (2)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .req_i   (req),
    .gnt_o   (gnt),
    .we_i    (we),
    .addr_i  (addr),
    .wdata_i (wdata),
    .be_i    (be),
    .rvalid_o(rvalid),
    .rdata_o (rdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
      $display("ok   %-12s obs=%h", tag, obs);
    end else begin
      $display("FAIL %-12s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req   = '0;
    we    = '0;
    addr  = '0;
    wdata = '0;
    be    = '0;
  endtask

  logic [NP-1:0] exp_g [8];
  logic [63:0]   rr_data [NP];
  logic [NP-1:0] eg;

  initial begin
    idle();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;

    // Reset: random inputs, outputs must stay quiet.
    for (int c = 0; c < 3; c++) begin
      req = NP'($urandom);
      we  = NP'($urandom);
      for (int p = 0; p < NP; p++) begin
        addr[p]  = AW'($urandom);
        wdata[p] = {$urandom, $urandom};
        be[p]    = BEW'($urandom);
      end
      #1;
      check("rst_gnt", 64'(gnt), 64'h0);
      check("rst_rvalid", 64'(rvalid), 64'h0);
      check("rst_rdata", 64'(rdata != '0), 64'h0);
      tick();
    end
    idle();
    rst_n = 1'b1;

    // First conflict after reset goes to port 0.
    req = 4'b1111;
    addr[0] = 10'd0; addr[1] = 10'd4; addr[2] = 10'd8; addr[3] = 10'd12;
    #1;
    check("rst_first", 64'(gnt), 64'h1);
    tick();
    idle();
    check("lat_early", 64'(rvalid), 64'h0);
    tick();
    check("lat_rvalid", 64'(rvalid), 64'h1);
    tick();

    // Parallel writes then reads on four distinct banks.
    req = 4'b1111;
    we  = 4'b1111;
    for (int p = 0; p < NP; p++) begin
      addr[p]  = AW'(p);
      wdata[p] = 64'hA0 + 64'(p);
      be[p]    = 8'hFF;
    end
    #1;
    check("par_wr_gnt", 64'(gnt), 64'hF);
    tick();
    we = '0;
    #1;
    check("par_rd_gnt", 64'(gnt), 64'hF);
    tick();
    idle();
    check("par_no_wrv", 64'(rvalid), 64'h0);
    tick();
    check("par_rvalid", 64'(rvalid), 64'hF);
    for (int p = 0; p < NP; p++) check("par_rdata", rdata[p], 64'hA0 + 64'(p));
    tick();
    check("par_drain", 64'(rvalid), 64'h0);
    check("par_rd_zero", 64'(rdata != '0), 64'h0);

    // Seed addresses 5 and 9 through port 3, then pulse reset to zero the pointers.
    req[3] = 1'b1; we[3] = 1'b1; be[3] = 8'hFF; addr[3] = 10'd5; wdata[3] = 64'hB5;
    tick();
    addr[3] = 10'd9; wdata[3] = 64'hB9;
    tick();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // Three ports contend for bank 1 for six cycles.
    rr_data[0] = 64'hA1; rr_data[1] = 64'hB5; rr_data[2] = 64'hB9; rr_data[3] = 64'h0;
    for (int k = 0; k < 8; k++) begin
      if (k < 6) begin
        req = 4'b0111;
        addr[0] = 10'd1; addr[1] = 10'd5; addr[2] = 10'd9;
        exp_g[k] = NP'(1 << (k % 3));
      end else begin
        idle();
        exp_g[k] = '0;
      end
      #1;
      check("rr_gnt", 64'(gnt), 64'(exp_g[k]));
      eg = (k >= 2) ? exp_g[k-2] : '0;
      check("rr_rvalid", 64'(rvalid), 64'(eg));
      for (int p = 0; p < NP; p++) begin
        if (eg[p]) check("rr_rdata", rdata[p], rr_data[p]);
      end
      tick();
    end

    // Byte enables: only the low four bytes are cleared.
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 10'd8; be[0] = 8'hFF; wdata[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    be[0] = 8'h0F; wdata[0] = 64'h0;
    tick();
    we[0] = 1'b0;
    tick();
    idle();
    tick();
    check("be_rvalid", 64'(rvalid), 64'h1);
    check("be_rdata", rdata[0], 64'hFFFF_FFFF_0000_0000);
    tick();

    // Out-of-range address: granted, write dropped, read returns zero.
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 10'd1020; be[2] = 8'hFF; wdata[2] = 64'h55;
    #1;
    check("oor_wr_gnt", 64'(gnt), 64'h4);
    tick();
    we[2] = 1'b0;
    #1;
    check("oor_rd_gnt", 64'(gnt), 64'h4);
    tick();
    idle();
    tick();
    check("oor_rvalid", 64'(rvalid), 64'h4);
    check("oor_rdata", rdata[2], 64'h0);
    tick();

    // Reset one cycle after an accepted read discards it and clears the pointers.
    req[1] = 1'b1; addr[1] = 10'd1;
    #1;
    check("mr_gnt", 64'(gnt), 64'h2);
    tick();
    idle();
    rst_n = 1'b0;
    #1;
    check("mr_rv_rst", 64'(rvalid), 64'h0);
    tick();
    rst_n = 1'b1;
    #1;
    check("mr_rv_due", 64'(rvalid), 64'h0);
    check("mr_rd_due", 64'(rdata != '0), 64'h0);
    tick();
    check("mr_rv_late", 64'(rvalid), 64'h0);
    req = 4'b1111;
    addr[0] = 10'd1; addr[1] = 10'd5; addr[2] = 10'd9; addr[3] = 10'd13;
    #1;
    check("mr_ptr", 64'(gnt), 64'h1);
    tick();
    idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
